uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

UART receive controller for the 8N1 receive path. It watches the synchronized serial line and detects and validates the start bit. A bit-period timer generates one `shift_strobe` per bit for the downstream 9-bit shift register, which holds 8 data bits LSB-first plus the stop bit. After the last shift it checks the stop bit and either pulses `load_buffer` to the receive data buffer or flags a framing error.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit period; must be ≥ 4.
- `FRAME_BITS`, default 9: strobes per frame (8 data + 1 stop); fixed by the shift register width.

- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `serial_in`  in  1  serial line, already synchronized; idle high
- `stop_bit`  in  1  shift register bit 8 (last bit shifted in)
- `shift_strobe`  out  1  one-cycle pulse; shift register samples `serial_in` on it
- `load_buffer`  out  1  one-cycle pulse; frame valid, downstream captures `packet_data`
- `framing_error`  out  1  sticky flag; last frame's stop bit was 0
- `rx_busy`  out  1  high whenever state ≠ IDLE

## Operation
- Internal `prev_rx` register holds `serial_in` delayed one cycle; resets to 0, so a line held low out of reset is never taken as a start.
- Start edge is `prev_rx == 1 && serial_in == 0`; it is only honoured in IDLE.
- States and transitions:
  - IDLE: on start edge, clear the bit counter and go to START_CHK.
  - START_CHK: wait HALF = CLKS_PER_BIT/2 (integer) cycles, then sample `serial_in`.
    - 0: clear `framing_error`, go to DATA.
    - 1: glitch; return to IDLE with no strobe.
  - DATA: every CLKS_PER_BIT cycles assert `shift_strobe` for one cycle and increment the bit count. After strobe FRAME_BITS, go to STOP_CHK.
  - STOP_CHK, one cycle only:
    - `stop_bit == 1`: `load_buffer` high this cycle.
    - `stop_bit == 0`: `framing_error` set at the closing edge.
    - Then go to IDLE.
- `shift_strobe` and `load_buffer` are Moore outputs decoded from state and counter.
- `framing_error` is a register. It holds until the next start bit passes START_CHK, or until reset.
- Timer width is `$clog2(CLKS_PER_BIT)`. Bit counter width is `$clog2(FRAME_BITS+1)`. Neither may wrap inside a frame.
- STOP_CHK falls at mid stop bit, so IDLE is re-entered about half a bit before the earliest possible next start edge. Back-to-back frames must be received with no gap.
- Reset at any time: state IDLE, counters 0, `prev_rx` 0, all outputs 0. A partial frame is discarded and produces no `load_buffer`.

## Timing
- E is the first cycle with `serial_in` 0 after a 1 (the start edge); N = CLKS_PER_BIT.
- START_CHK sample at E+HALF.
- `shift_strobe` high at E+HALF+k·N for k = 1..9.
- STOP_CHK cycle is E+HALF+9N+1; `load_buffer` is high in that cycle.
- `framing_error` becomes visible at E+HALF+9N+2.
- `rx_busy` is high from E+1 through the STOP_CHK cycle inclusive.
- Reset values: `shift_strobe`=0, `load_buffer`=0, `framing_error`=0, `rx_busy`=0.

## Structure
- Package `uart_rx_pkg`:
  - `rx_state_t` enum {IDLE, START_CHK, DATA, STOP_CHK};
  - `DEFAULT_CLKS_PER_BIT` = 10;
  - `RX_FRAME_BITS` = 9.
- One sub-module, `rx_bit_timer`: a parameterized counter with clear and enable and a rollover pulse at a programmable value. One instance counts clocks per bit, a second counts bits.
- The FSM and edge detect stay in `uart_rx_ctrl`.

## Test plan
All scenarios use N = 10, HALF = 5.
- **Clean frame:** frame 0xA5 LSB-first with stop 1. Required: 9 strobes at E+15, 25, …, 95; `load_buffer` at E+96; `framing_error` 0; shift register `packet_data` = 0xA5.
- **Start glitch:** `serial_in` low for 3 cycles, then high. Required: IDLE again at E+6; no `shift_strobe`; `rx_busy` high only for E+1..E+5.
- **Bad stop bit:** frame 0x3C with stop 0. Required: no `load_buffer`; `framing_error`=1 from E+97. A following valid frame clears it from E'+6 and delivers its own `load_buffer`.
- **Back-to-back frames:** 0x01 then 0xFE with a minimal one-bit stop. Required: two `load_buffer` pulses exactly 100 cycles apart; both bytes correct.
- **Reset mid-frame:** assert `rst` between strobes 4 and 5. Required: all outputs 0 immediately. After release with the line held low, no start is detected until the line returns high, then a valid falling edge occurs.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and defaults for the 8N1 UART receive controller.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP_CHK
  } rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10;
  localparam int RX_FRAME_BITS        = 9;

endpackage

// File: rtl/rx_bit_timer.sv
// Clearable, enabled up-counter that wraps to zero after reaching i_max,
// flagging that cycle with a one-cycle rollover pulse.
module rx_bit_timer #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_max,
  output logic             o_rollover
);

  logic [WIDTH-1:0] r_count;

  assign o_rollover = i_enable && (r_count == i_max);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= o_rollover ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 receive controller: start-bit validation, per-bit shift strobes,
// stop-bit check with buffer load or sticky framing error.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FRAME_BITS   = RX_FRAME_BITS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_serial_in,
  input  logic i_stop_bit,
  output logic o_shift_strobe,
  output logic o_load_buffer,
  output logic o_framing_error,
  output logic o_rx_busy
);

  localparam int TW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(FRAME_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [TW-1:0] HALF_MAX = TW'(HALF - 1);
  localparam logic [TW-1:0] BIT_MAX  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  rx_state_t       r_state;
  rx_state_t       w_next_state;
  logic            r_prev_rx;
  logic            r_framing_error;
  logic            w_start_edge;
  logic            w_timer_clr;
  logic            w_timer_en;
  logic [TW-1:0]   w_timer_max;
  logic            w_timer_roll;
  logic            w_bit_roll;
  logic            w_shift_strobe;
  logic            w_load_buffer;
  logic            w_clear_ferr;
  logic            w_set_ferr;

  assign w_start_edge   = r_prev_rx && !i_serial_in;
  assign w_timer_clr    = (r_state == IDLE);
  assign w_timer_en     = (r_state == START_CHK) || (r_state == DATA);
  assign w_timer_max    = (r_state == START_CHK) ? HALF_MAX : BIT_MAX;
  assign w_shift_strobe = (r_state == DATA) && w_timer_roll;

  // Same timer measures the half-bit start check, then full bit periods.
  rx_bit_timer #(.WIDTH(TW)) u_clk_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_timer_clr),
    .i_enable   (w_timer_en),
    .i_max      (w_timer_max),
    .o_rollover (w_timer_roll)
  );

  rx_bit_timer #(.WIDTH(BW)) u_bit_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_timer_clr),
    .i_enable   (w_shift_strobe),
    .i_max      (LAST_BIT),
    .o_rollover (w_bit_roll)
  );

  always_comb begin
    w_next_state  = r_state;
    w_load_buffer = 1'b0;
    w_clear_ferr  = 1'b0;
    w_set_ferr    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_edge) w_next_state = START_CHK;
      end
      START_CHK: begin
        if (w_timer_roll) begin
          if (!i_serial_in) begin
            w_next_state = DATA;
            w_clear_ferr = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      DATA: begin
        if (w_bit_roll) w_next_state = STOP_CHK;
      end
      STOP_CHK: begin
        w_next_state  = IDLE;
        w_load_buffer = i_stop_bit;
        w_set_ferr    = !i_stop_bit;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // prev_rx resets low so a line held low out of reset never looks like a start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= IDLE;
      r_prev_rx       <= 1'b0;
      r_framing_error <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_prev_rx <= i_serial_in;
      if (w_set_ferr) begin
        r_framing_error <= 1'b1;
      end else if (w_clear_ferr) begin
        r_framing_error <= 1'b0;
      end
    end
  end

  assign o_shift_strobe  = w_shift_strobe;
  assign o_load_buffer   = w_load_buffer;
  assign o_framing_error = r_framing_error;
  assign o_rx_busy       = (r_state != IDLE);

endmodule
